// File: rtl/game_sequencer.sv
// Frame-level brick-breaker game controller: sequences serve/play/miss/win/over
// phases, gates motion updates to one per frame, and owns lives/score/level.
module game_sequencer #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int FLASH_FRAMES = 120,
    parameter int SCORE_W      = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               out_bounds,
    input  logic               brick_hit,
    input  logic               brick_clear,
    output logic               update_en,
    output logic               ball_hold,
    output logic               bricks_reload,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         level,
    output logic [2:0]         state
);

    localparam int MAX_FRAMES = (SERVE_FRAMES > FLASH_FRAMES) ? SERVE_FRAMES : FLASH_FRAMES;
    localparam int FCNT_W     = $clog2(MAX_FRAMES + 1);

    localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  FLASH_LAST = FCNT_W'(FLASH_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  FCNT_ONE   = FCNT_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_WIN   = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [2:0]          lives_q, lives_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [3:0]          level_q, level_d;
    logic                start_q;
    logic                update_q, update_d;
    logic                hold_q, hold_d;
    logic                reload_q, reload_d;
    logic                start_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fcnt_q   <= '0;
            lives_q  <= LIVES_INIT;
            score_q  <= '0;
            level_q  <= '0;
            start_q  <= 1'b0;
            update_q <= 1'b0;
            hold_q   <= 1'b1;
            reload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            lives_q  <= lives_d;
            score_q  <= score_d;
            level_q  <= level_d;
            start_q  <= start;
            update_q <= update_d;
            hold_q   <= hold_d;
            reload_q <= reload_d;
        end
    end

    always_comb begin
        start_rise = start & ~start_q;
        state_d    = state_q;
        fcnt_d     = frame_tick ? (fcnt_q + FCNT_ONE) : fcnt_q;
        lives_d    = lives_q;
        score_d    = score_q;
        level_d    = level_q;
        update_d   = 1'b0;
        reload_d   = 1'b0;

        // Hits still count on the cycle PLAY exits, so score is judged on the current state.
        if (brick_hit && (state_q != S_IDLE) && (state_q != S_OVER) && (score_q != '1)) begin
            score_d = score_q + SCORE_ONE;
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    state_d  = S_SERVE;
                    lives_d  = LIVES_INIT;
                    score_d  = '0;
                    level_d  = '0;
                    reload_d = 1'b1;
                end
            end
            S_SERVE: begin
                if (frame_tick && (fcnt_q == SERVE_LAST)) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                update_d = frame_tick;
                if (brick_clear) begin
                    state_d = S_WIN;
                end else if (out_bounds) begin
                    state_d = S_MISS;
                    lives_d = lives_q - 3'd1;
                end
            end
            S_MISS: begin
                if (frame_tick && (fcnt_q == FLASH_LAST)) begin
                    state_d = (lives_q == 3'd0) ? S_OVER : S_SERVE;
                end
            end
            S_WIN: begin
                if (frame_tick && (fcnt_q == FLASH_LAST)) begin
                    state_d  = S_SERVE;
                    level_d  = level_q + 4'd1;
                    reload_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            fcnt_d = '0;
        end
        hold_d = (state_d != S_PLAY);
    end

    assign update_en     = update_q;
    assign ball_hold     = hold_q;
    assign bricks_reload = reload_q;
    assign lives         = lives_q;
    assign score         = score_q;
    assign level         = level_q;
    assign state         = state_q;

endmodule
